load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 tb/tb_load_store_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Sequences byte/halfword loads and stores onto a 16-bit big-endian data
//   memory with a combinational read port. Byte stores are performed as a
//   read-modify-write of the addressed halfword; byte A+1 is preserved.
//   Addresses above 62 are rejected with resp_err and no memory access.
//
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     defined   : a halfword access at an odd address is rejected as an error
//     undefined : odd-address halfword accesses proceed normally
//
// Ports
//   clock, reset                 clock; asynchronous active-high reset
//   req_valid / req_ready        request handshake (ready only in IDLE)
//   req_write, req_byte,         store/load, byte/halfword, sign-extend byte load
//   req_signed
//   req_addr, req_wdata          byte address, store data (byte store uses [7:0])
//   resp_valid, resp_rdata,      one-cycle completion pulse, load data, reject flag
//   resp_err
//   mem_addr, mem_wdata,         data memory address, write data,
//   mem_we, mem_re, mem_rdata    write/read strobes, read data (big-endian)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request, req_ready = 1
// RD     | memory read, mem_rdata captured into buf_q at the closing edge
// WR     | one-cycle memory write (halfword, or merged byte for byte store)
// RESP   | resp_valid pulse, then back to IDLE

module load_store_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_byte,
   input  logic        req_signed,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic        resp_err,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [15:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic        byte_q, byte_d;
   logic        signed_q, signed_d;
   logic        err_q, err_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] buf_q, buf_d;

   logic        req_err;

   always_comb begin
      req_err = (req_addr > 16'd62);
`ifdef LSU_MISALIGN_TRAP_EN
      if (!req_byte && req_addr[0]) req_err = 1'b1;
`endif
   end

   // state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         write_q  <= 1'b0;
         byte_q   <= 1'b0;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= 16'h0000;
         wdata_q  <= 16'h0000;
         buf_q    <= 16'h0000;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         byte_q   <= byte_d;
         signed_q <= signed_d;
         err_q    <= err_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         buf_q    <= buf_d;
      end
   end

   // next state and request/buffer capture
   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      byte_d   = byte_q;
      signed_d = signed_q;
      err_d    = err_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      buf_d    = buf_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d  = req_write;
               byte_d   = req_byte;
               signed_d = req_signed;
               err_d    = req_err;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               if (req_err)                    state_d = S_RESP;
               else if (req_write && !req_byte) state_d = S_WR;
               else                            state_d = S_RD;
            end
         end
         S_RD: begin
            buf_d   = mem_rdata;
            state_d = write_q ? S_WR : S_RESP;
         end
         S_WR:    state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // outputs are decoded from state so reset clears them immediately
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = 16'h0000;
      mem_addr   = 16'h0000;
      mem_wdata  = 16'h0000;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      case (state_q)
         S_IDLE: req_ready = 1'b1;
         S_RD: begin
            mem_re   = 1'b1;
            mem_addr = addr_q;
         end
         S_WR: begin
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            // byte store replaces byte A (upper lane) and keeps byte A+1
            mem_wdata = byte_q ? {wdata_q[7:0], buf_q[7:0]} : wdata_q;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            if (!err_q && !write_q) begin
               if (!byte_q)       resp_rdata = buf_q;
               else if (signed_q) resp_rdata = {{8{buf_q[15]}}, buf_q[15:8]};
               else               resp_rdata = {8'h00, buf_q[15:8]};
            end
         end
         default: req_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write, req_byte, req_signed;
   logic [15:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [15:0] resp_rdata;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, mem_re;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   load_store_unit dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_byte(req_byte), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
   );

   // behavioural data memory: 64 bytes, big-endian halfword view
   logic [7:0] mem [0:63];
   logic       mem_init;
   logic [5:0] ma0, ma1;
   assign ma0 = mem_addr[5:0];
   assign ma1 = ma0 + 6'd1;
   assign mem_rdata = {mem[ma0], mem[ma1]};

   always @(posedge clock) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
         mem[7]  <= 8'h5A; mem[8]  <= 8'hC3;
         mem[10] <= 8'h12; mem[11] <= 8'h34;
         mem[20] <= 8'h80;
         mem[30] <= 8'h11; mem[31] <= 8'h22;
         mem[62] <= 8'h77; mem[63] <= 8'h66;
      end else if (mem_we) begin
         mem[ma0] <= mem_wdata[15:8];
         mem[ma1] <= mem_wdata[7:0];
      end
   end

   typedef struct {
      string       name;
      logic        wr, by, sg;
      logic [15:0] addr, wdata;
      logic [15:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_re;
      int          exp_we;
      logic [15:0] exp_wd;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_access(input vec_t v);
      int lat, re_cnt, we_cnt, wait_cnt;
      logic both, seen;
      logic [15:0] wd_seen, rd_seen;
      logic er_seen;
      lat = 0; re_cnt = 0; we_cnt = 0; both = 1'b0; seen = 1'b0;
      wd_seen = 16'h0; rd_seen = 16'h0; er_seen = 1'b0;
      wait_cnt = 0;
      @(negedge clock);
      while (!req_ready && wait_cnt < 10) begin
         @(negedge clock);
         wait_cnt++;
      end
      chk({v.name, " ready"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_write = v.wr; req_byte = v.by; req_signed = v.sg;
      req_addr = v.addr; req_wdata = v.wdata;
      @(posedge clock);
      while (!seen && lat < 10) begin
         @(negedge clock);
         req_valid = 1'b0;
         lat++;
         if (mem_re) re_cnt++;
         if (mem_we) begin
            we_cnt++;
            wd_seen = mem_wdata;
         end
         if (mem_re && mem_we) both = 1'b1;
         if (resp_valid) begin
            seen = 1'b1;
            rd_seen = resp_rdata;
            er_seen = resp_err;
         end
      end
      chk({v.name, " latency"}, lat, seen ? v.exp_lat : 99);
      chk({v.name, " rdata"}, {16'd0, rd_seen}, {16'd0, v.exp_rdata});
      chk({v.name, " err"}, {31'd0, er_seen}, {31'd0, v.exp_err});
      chk({v.name, " re_cycles"}, re_cnt, v.exp_re);
      chk({v.name, " we_cycles"}, we_cnt, v.exp_we);
      chk({v.name, " we_re_overlap"}, {31'd0, both}, 32'd0);
      if (v.exp_we != 0) chk({v.name, " mem_wdata"}, {16'd0, wd_seen}, {16'd0, v.exp_wd});
   endtask

   function automatic vec_t mk(string name, logic wr, logic by, logic sg,
                               logic [15:0] addr, logic [15:0] wdata,
                               logic [15:0] exp_rdata, logic exp_err, int exp_lat,
                               int exp_re, int exp_we, logic [15:0] exp_wd);
      vec_t v;
      v.name = name; v.wr = wr; v.by = by; v.sg = sg; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
      v.exp_re = exp_re; v.exp_we = exp_we; v.exp_wd = exp_wd;
      return v;
   endfunction

   vec_t tail;
   int   cyc;
   logic bad_we, bad_rv;

   initial begin
      //            name             wr by sg addr      wdata     rdata    err lat re we wd
      vecs[0]  = mk("st_hw_4",       1, 0, 0, 16'd4,   16'hBEEF, 16'h0000, 0, 2, 0, 1, 16'hBEEF);
      vecs[1]  = mk("ld_hw_4",       0, 0, 0, 16'd4,   16'h0000, 16'hBEEF, 0, 2, 1, 0, 16'h0000);
      vecs[2]  = mk("st_by_10",      1, 1, 0, 16'd10,  16'h77A5, 16'h0000, 0, 3, 1, 1, 16'hA534);
      vecs[3]  = mk("ld_hw_10",      0, 0, 0, 16'd10,  16'h0000, 16'hA534, 0, 2, 1, 0, 16'h0000);
      vecs[4]  = mk("ld_bs_20",      0, 1, 1, 16'd20,  16'h0000, 16'hFF80, 0, 2, 1, 0, 16'h0000);
      vecs[5]  = mk("ld_bu_20",      0, 1, 0, 16'd20,  16'h0000, 16'h0080, 0, 2, 1, 0, 16'h0000);
      vecs[6]  = mk("ld_hw_62",      0, 0, 0, 16'd62,  16'h0000, 16'h7766, 0, 2, 1, 0, 16'h0000);
      vecs[7]  = mk("ld_by_63",      0, 1, 0, 16'd63,  16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000);
      vecs[8]  = mk("st_hw_63",      1, 0, 0, 16'd63,  16'h1234, 16'h0000, 1, 1, 0, 0, 16'h0000);
      vecs[9]  = mk("st_by_63",      1, 1, 0, 16'd63,  16'h00EE, 16'h0000, 1, 1, 0, 0, 16'h0000);
      vecs[10] = mk("ld_bu_62",      0, 1, 0, 16'd62,  16'h0000, 16'h0077, 0, 2, 1, 0, 16'h0000);
      vecs[11] = mk("ld_bs_11",      0, 1, 1, 16'd11,  16'h0000, 16'h0034, 0, 2, 1, 0, 16'h0000);
      vecs[12] = mk("st_hw_ffff",    1, 0, 0, 16'hFFFF,16'h5555, 16'h0000, 1, 1, 0, 0, 16'h0000);
`ifdef LSU_MISALIGN_TRAP_EN
      vecs[13] = mk("ld_hw_7_mis",   0, 0, 0, 16'd7,   16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000);
`else
      vecs[13] = mk("ld_hw_7_mis",   0, 0, 0, 16'd7,   16'h0000, 16'h5AC3, 0, 2, 1, 0, 16'h0000);
`endif

      reset = 1'b1; mem_init = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
      req_addr = 16'h0; req_wdata = 16'h0;
      repeat (3) @(negedge clock);
      chk("rst req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst outputs", {resp_valid, resp_err, mem_we, mem_re, resp_rdata, 12'd0},
          32'd0);
      chk("rst mem_addr_wdata", {mem_addr, mem_wdata}, 32'd0);
      reset = 1'b0; mem_init = 1'b0;

      for (int i = 0; i < 14; i++) do_access(vecs[i]);

      // busy: req_ready low while a load is in RD
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 16'd4;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      chk("busy req_ready", {31'd0, req_ready}, 32'd0);
      repeat (3) @(negedge clock);

      // reset asserted during RD of a byte store aborts it
      req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_addr = 16'd30;
      req_wdata = 16'h0099;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      chk("mid_rst in_rd mem_re", {31'd0, mem_re}, 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst req_ready", {31'd0, req_ready}, 32'd1);
      chk("mid_rst strobes", {30'd0, mem_re, mem_we}, 32'd0);
      bad_we = 1'b0; bad_rv = 1'b0;
      for (cyc = 0; cyc < 3; cyc++) begin
         @(negedge clock);
         if (mem_we) bad_we = 1'b1;
         if (resp_valid) bad_rv = 1'b1;
      end
      reset = 1'b0;
      for (cyc = 0; cyc < 3; cyc++) begin
         @(negedge clock);
         if (mem_we) bad_we = 1'b1;
         if (resp_valid) bad_rv = 1'b1;
      end
      chk("mid_rst no_we", {31'd0, bad_we}, 32'd0);
      chk("mid_rst no_resp", {31'd0, bad_rv}, 32'd0);
      tail = mk("mid_rst ld_hw_30", 0, 0, 0, 16'd30, 16'h0000, 16'h1122, 0, 2, 1, 0, 16'h0000);
      do_access(tail);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
